// File: rtl/stream_width_upsizer.sv
// stream_width_upsizer: packs RATIO narrow AXI-Stream beats into one wide
// registered beat, lane 0 first; s_in_tlast closes a group early (zero pad).
// Ports: clk, rst_n (sync, active-low);
//   s_in_tdata/tvalid/tlast/tready  narrow slave side;
//   m_out_tdata/tvalid/tlast/tready wide master side;
//   m_out_tkeep  filled-lane mask, only with macro UPSIZE_TKEEP_EN.
`timescale 1ns/1ps
module stream_width_upsizer #(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  s_in_tdata,
  input  logic                 s_in_tvalid,
  input  logic                 s_in_tlast,
  output logic                 s_in_tready,
  output logic [OUT_WIDTH-1:0] m_out_tdata,
  output logic                 m_out_tvalid,
  output logic                 m_out_tlast,
  input  logic                 m_out_tready
`ifdef UPSIZE_TKEEP_EN
  ,
  output logic [RATIO-1:0]     m_out_tkeep
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_data;
  logic                 r_last;
  logic [OUT_WIDTH-1:0] w_beat;
  logic                 w_ready;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic                 w_stall;
  logic                 w_close;
  logic                 w_accum;

  assign m_out_tvalid = (r_state == S_HOLD);
  assign m_out_tdata  = r_data;
  assign m_out_tlast  = r_last;

  assign w_ready     = ~m_out_tvalid | m_out_tready;
  assign s_in_tready = w_ready;
  assign w_in_hs     = s_in_tvalid & w_ready;
  assign w_out_hs    = m_out_tvalid & m_out_tready;
  assign w_stall     = m_out_tvalid & ~m_out_tready;

  assign w_close = w_in_hs &
    (s_in_tlast | (r_cnt == CNT_W'(RATIO - 1)));

  assign w_accum = ~w_close & ~w_stall &
    (w_in_hs | (r_cnt != '0));

  // Lanes above cnt are still zero since the last
  // clear, so OR-ing the shifted beat fills lane cnt.
  assign w_beat = OUT_WIDTH'(s_in_tdata)
    << (32'(r_cnt) * IN_WIDTH);

  always_comb begin
    w_state_nxt = S_IDLE;
    unique case (1'b1)
      w_close: w_state_nxt = S_HOLD;
      w_stall: w_state_nxt = S_HOLD;
      w_accum: w_state_nxt = S_ACCUM;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_close) begin
        r_cnt  <= '0;
        r_acc  <= '0;
        r_data <= r_acc | w_beat;
        r_last <= s_in_tlast;
      end else if (w_in_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= r_acc | w_beat;
      end
    end
  end

  // w_out_hs only matters through w_stall; keep it
  // visible for debug alongside the state.
  logic w_unused;
  assign w_unused = w_out_hs;

`ifdef UPSIZE_TKEEP_EN
  logic [RATIO-1:0] r_keep;
  logic [RATIO-1:0] w_keep;

  always_comb begin
    w_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_keep[i] = (i <= int'(r_cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_keep <= '0;
    end else if (w_close) begin
      r_keep <= w_keep;
    end
  end

  assign m_out_tkeep = r_keep;
`endif

endmodule

// File: tb/tb_stream_width_upsizer.sv
// tb_stream_width_upsizer: directed + random bench for stream_width_upsizer
// with a queue-based packing model checked every cycle.
`timescale 1ns/1ps
module tb_stream_width_upsizer;

  localparam int IN_WIDTH = 8;
  localparam int RATIO    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_in_tdata = '0;
  logic        s_in_tvalid = 1'b0;
  logic        s_in_tlast = 1'b0;
  logic        s_in_tready;
  logic [31:0] m_out_tdata;
  logic        m_out_tvalid;
  logic        m_out_tlast;
  logic        m_out_tready = 1'b0;
`ifdef UPSIZE_TKEEP_EN
  logic [3:0]  m_out_tkeep;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  stream_width_upsizer #(
    .IN_WIDTH(IN_WIDTH),
    .RATIO(RATIO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_in_tdata(s_in_tdata),
    .s_in_tvalid(s_in_tvalid),
    .s_in_tlast(s_in_tlast),
    .s_in_tready(s_in_tready),
    .m_out_tdata(m_out_tdata),
    .m_out_tvalid(m_out_tvalid),
    .m_out_tlast(m_out_tlast),
    .m_out_tready(m_out_tready)
`ifdef UPSIZE_TKEEP_EN
    ,
    .m_out_tkeep(m_out_tkeep)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, exp);
    end
  endtask

  // Model: output register contents plus a queue of
  // bytes gathered for the current group.
  logic        mv = 1'b0;
  logic        ml = 1'b0;
  logic [31:0] md = '0;
  logic [3:0]  mk = '0;
  logic [7:0]  q[$];
  logic        known = 1'b0;

  always @(negedge clk) begin
    logic rdy;
    if (known) begin
      chk("cmp_tready", s_in_tready,
          !mv || m_out_tready);
      chk("cmp_tvalid", m_out_tvalid, mv);
      if (mv) begin
        chk("cmp_tdata", m_out_tdata, md);
        chk("cmp_tlast", m_out_tlast, ml);
`ifdef UPSIZE_TKEEP_EN
        chk("cmp_tkeep", m_out_tkeep, mk);
`endif
      end
    end
    if (!rst_n) begin
      mv = 1'b0;
      ml = 1'b0;
      md = '0;
      mk = '0;
      q.delete();
      known = 1'b1;
    end else if (known) begin
      rdy = !mv || m_out_tready;
      if (mv && m_out_tready) mv = 1'b0;
      if (s_in_tvalid && rdy) begin
        q.push_back(s_in_tdata);
        if (q.size() == RATIO || s_in_tlast) begin
          md = '0;
          foreach (q[i])
            md = md | (32'(q[i]) << (8 * i));
          mk = 4'((1 << q.size()) - 1);
          ml = s_in_tlast;
          mv = 1'b1;
          q.delete();
        end
      end
    end
  end

  task automatic cyc(input logic v,
                     input logic [7:0] d,
                     input logic l,
                     input logic r);
    s_in_tvalid  = v;
    s_in_tdata   = d;
    s_in_tlast   = l;
    m_out_tready = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_exp [4] = '{
    32'h03020100, 32'h07060504,
    32'h0B0A0908, 32'h0F0E0D0C
  };

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("rst_valid", m_out_tvalid, 0);
    chk("rst_data", m_out_tdata, 0);
    chk("rst_last", m_out_tlast, 0);
    chk("rst_ready", s_in_tready, 1);
`ifdef UPSIZE_TKEEP_EN
    chk("rst_keep", m_out_tkeep, 0);
`endif
    rst_n = 1'b1;

    // full group
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 0, 1);
    cyc(1, 8'h33, 0, 1);
    chk("full_pre_valid", m_out_tvalid, 0);
    cyc(1, 8'h44, 0, 1);
    chk("full_valid", m_out_tvalid, 1);
    chk("full_data", m_out_tdata, 32'h44332211);
    chk("full_last", m_out_tlast, 0);
`ifdef UPSIZE_TKEEP_EN
    chk("full_keep", m_out_tkeep, 4'b1111);
`endif

    // backpressure
    repeat (5) begin
      cyc(0, 8'h00, 0, 0);
      chk("bp_ready", s_in_tready, 0);
      chk("bp_valid", m_out_tvalid, 1);
      chk("bp_data", m_out_tdata, 32'h44332211);
    end
    m_out_tready = 1'b1;
    #1;
    chk("bp_release_ready", s_in_tready, 1);
    cyc(0, 8'h00, 0, 1);
    chk("bp_drained", m_out_tvalid, 0);

    // early tlast, then reload while handshaking
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 1, 1);
    chk("early_data", m_out_tdata, 32'h00002211);
    chk("early_last", m_out_tlast, 1);
`ifdef UPSIZE_TKEEP_EN
    chk("early_keep", m_out_tkeep, 4'b0011);
`endif
    cyc(1, 8'h77, 1, 1);
    chk("reload_valid", m_out_tvalid, 1);
    chk("reload_data", m_out_tdata, 32'h00000077);
    cyc(0, 8'h00, 0, 1);
    chk("reload_drained", m_out_tvalid, 0);

    // lane-0 tlast
    cyc(1, 8'h5A, 1, 1);
    chk("lane0_data", m_out_tdata, 32'h0000005A);
    chk("lane0_last", m_out_tlast, 1);
`ifdef UPSIZE_TKEEP_EN
    chk("lane0_keep", m_out_tkeep, 4'b0001);
`endif
    cyc(0, 8'h00, 0, 1);

    // streaming
    for (int i = 0; i < 16; i++) begin
      s_in_tvalid  = 1'b1;
      s_in_tdata   = 8'(i);
      s_in_tlast   = 1'b0;
      m_out_tready = 1'b1;
      #1;
      chk("stream_ready", s_in_tready, 1);
      @(posedge clk);
      #1;
      if (i % 4 == 3) begin
        chk("stream_valid", m_out_tvalid, 1);
        chk("stream_data", m_out_tdata,
            stream_exp[i / 4]);
      end
    end
    cyc(0, 8'h00, 0, 1);

    // reset mid-group
    cyc(1, 8'h01, 0, 1);
    cyc(1, 8'h02, 0, 1);
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 1);
    rst_n = 1'b1;
    chk("midrst_valid", m_out_tvalid, 0);
    cyc(1, 8'hAA, 0, 1);
    cyc(1, 8'hBB, 0, 1);
    cyc(1, 8'hCC, 0, 1);
    chk("midrst_pre_valid", m_out_tvalid, 0);
    cyc(1, 8'hDD, 0, 1);
    chk("midrst_valid2", m_out_tvalid, 1);
    chk("midrst_data", m_out_tdata, 32'hDDCCBBAA);
    cyc(0, 8'h00, 0, 1);

    // random traffic
    repeat (3000) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 9) < 7,
          8'($urandom),
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) < 6);
    end
    rst_n = 1'b1;
    repeat (10) cyc(0, 8'h00, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
